// File: rtl/pcs_rx_decoder.sv
// 40GBASE-R receive 64b/66b decoder: four 66-bit blocks per core_clk in, one registered
// 256-bit XLGMII data/control word out, with per-block frame sequencing and /E/ counting.
module pcs_rx_decoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 core_clk,
  input  logic                 core_reset,
  input  logic                 rx_locked,
  input  logic                 rx_block_valid,
  input  logic                 rx_marker,
  input  logic [263:0]         rx_block,
  output logic [255:0]         rx_data,
  output logic [31:0]          rx_ctrl,
  output logic                 rx_valid,
  output logic                 rx_err_block,
  output logic [ERR_CNT_W-1:0] rx_err_count,
  input  logic                 rx_err_clear
);

  typedef enum logic [1:0] {ST_INIT, ST_C, ST_D, ST_E} state_e;
  typedef enum logic [2:0] {CL_C, CL_S, CL_T, CL_D, CL_E} class_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    class_e      cls;
  } lane_dec_t;

  localparam logic [63:0] ERR_LANE = {8{8'hFE}};

  function automatic lane_dec_t decode_block(input logic [65:0] b);
    lane_dec_t r;
    int        n;
    r.data = ERR_LANE;
    r.ctrl = 8'hFF;
    r.cls  = CL_E;
    n      = -1;
    if (b[1:0] == 2'b10) begin
      r.data = b[65:2];
      r.ctrl = 8'h00;
      r.cls  = CL_D;
    end else if (b[1:0] == 2'b01) begin
      case (b[9:2])
        8'h1E: if (b[65:10] == '0) begin
          r.data = {8{8'h07}};
          r.cls  = CL_C;
        end
        8'h78: begin
          r.data = {b[65:10], 8'hFB};
          r.ctrl = 8'h01;
          r.cls  = CL_S;
        end
        8'h4B: begin
          r.data = {{4{8'h07}}, b[33:10], 8'h9C};
          r.ctrl = 8'hF1;
          r.cls  = CL_C;
        end
        8'h87: n = 0;
        8'h99: n = 1;
        8'hAA: n = 2;
        8'hB4: n = 3;
        8'hCC: n = 4;
        8'hD2: n = 5;
        8'hE1: n = 6;
        8'hFF: n = 7;
        default: ;
      endcase
      // Terminate: n payload bytes, then /T/, then idles fill the block.
      if (n >= 0) begin
        r.cls = CL_T;
        for (int k = 0; k < 8; k++) begin
          if (k < n) begin
            r.data[8*k +: 8] = b[10+8*k +: 8];
            r.ctrl[k]        = 1'b0;
          end else begin
            r.data[8*k +: 8] = (k == n) ? 8'hFD : 8'h07;
            r.ctrl[k]        = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic state_e next_st(input state_e s, input class_e c);
    state_e ns;
    case (s)
      ST_C:    ns = (c == CL_C) ? ST_C : (c == CL_S) ? ST_D : ST_E;
      ST_D:    ns = (c == CL_D) ? ST_D : (c == CL_T) ? ST_C : ST_E;
      ST_E:    ns = (c == CL_C) ? ST_C : (c == CL_S) ? ST_D : ST_E;
      default: ns = (c == CL_C) ? ST_C : (c == CL_S) ? ST_D : ST_INIT;
    endcase
    return ns;
  endfunction

  state_e                state, state_next;
  state_e                lane_st [0:4];
  lane_dec_t             dec     [0:3];
  logic [3:0]            lane_err;
  logic [255:0]          word_data;
  logic [31:0]           word_ctrl;
  logic [2:0]            err_n;
  logic [ERR_CNT_W:0]    err_sum;
  logic                  accept;

  assign accept = rx_locked & rx_block_valid & ~rx_marker;

  // State register.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) state <= ST_INIT;
    // NOTE: state is updated with <= so every reader in this edge sees the old value.
    else            state <= state_next;
  end

  // Next state: lanes chained in time order within one cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    lane_st[0] = state;
    lane_err   = '0;
    for (int i = 0; i < 4; i++) begin
      dec[i]         = decode_block(rx_block[66*i +: 66]);
      lane_st[i+1]   = next_st(lane_st[i], dec[i].cls);
      lane_err[i]    = (lane_st[i+1] == ST_E) || (lane_st[i+1] == ST_INIT);
    end
    state_next = state;
    if (!rx_locked)  state_next = ST_INIT;
    else if (accept) state_next = lane_st[4];
  end

  // Output word: lanes that broke sequencing are replaced by /E/.
  always_comb begin
    word_data = '0;
    word_ctrl = '0;
    err_n     = '0;
    for (int i = 0; i < 4; i++) begin
      word_data[64*i +: 64] = lane_err[i] ? ERR_LANE : dec[i].data;
      word_ctrl[8*i +: 8]   = lane_err[i] ? 8'hFF    : dec[i].ctrl;
      err_n                 = err_n + {2'b00, lane_err[i]};
    end
    err_sum = {1'b0, rx_err_count} + {{(ERR_CNT_W-2){1'b0}}, err_n};
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      rx_data      <= {32{8'h07}};
      rx_ctrl      <= '1;
      rx_valid     <= 1'b0;
      rx_err_block <= 1'b0;
      rx_err_count <= '0;
    end else begin
      rx_valid <= accept;
      if (accept) begin
        rx_data      <= word_data;
        rx_ctrl      <= word_ctrl;
        rx_err_block <= |lane_err;
      end
      if (rx_err_clear)         rx_err_count <= '0;
      else if (accept)          rx_err_count <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pcs_rx_decoder.sv
// Directed bench for pcs_rx_decoder: vector table of accepted/held words plus a hand-written
// saturation and clear-priority sequence for the errored-block counter.
module tb_pcs_rx_decoder;

  logic         core_clk = 1'b0;
  logic         core_reset = 1'b1;
  logic         rx_locked = 1'b0;
  logic         rx_block_valid = 1'b0;
  logic         rx_marker = 1'b0;
  logic [263:0] rx_block = '0;
  logic         rx_err_clear = 1'b0;
  logic [255:0] rx_data;
  logic [31:0]  rx_ctrl;
  logic         rx_valid;
  logic         rx_err_block;
  logic [15:0]  rx_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  pcs_rx_decoder #(.ERR_CNT_W(16)) dut (
    .core_clk       (core_clk),
    .core_reset     (core_reset),
    .rx_locked      (rx_locked),
    .rx_block_valid (rx_block_valid),
    .rx_marker      (rx_marker),
    .rx_block       (rx_block),
    .rx_data        (rx_data),
    .rx_ctrl        (rx_ctrl),
    .rx_valid       (rx_valid),
    .rx_err_block   (rx_err_block),
    .rx_err_count   (rx_err_count),
    .rx_err_clear   (rx_err_clear)
  );

  always #5 core_clk = ~core_clk;

  // Input blocks.
  localparam logic [65:0] IDLE_B  = {56'h0, 8'h1E, 2'b01};
  localparam logic [65:0] START_B = {56'h17161514131211, 8'h78, 2'b01};
  localparam logic [65:0] TERM_B  = {56'h000000A3A2A1A0, 8'hCC, 2'b01};
  localparam logic [65:0] OS_B    = {56'h00000000C3C2C1, 8'h4B, 2'b01};
  localparam logic [65:0] BADI_B  = {56'h00000000000001, 8'h1E, 2'b01};
  localparam logic [65:0] BADT_B  = {56'h0, 8'h55, 2'b01};
  localparam logic [65:0] SYNC3_B = {64'hDEADBEEFCAFEF00D, 2'b11};
  localparam logic [63:0] D1 = 64'h1111111111111111, D2 = 64'h2222222222222222;
  localparam logic [63:0] D3 = 64'h3333333333333333, D4 = 64'h4444444444444444;
  localparam logic [63:0] D5 = 64'h5555555555555555, D6 = 64'h6666666666666666;
  localparam logic [63:0] D7 = 64'h7777777777777777;

  // Expected lane outputs.
  localparam logic [63:0] IDLE_O  = 64'h0707070707070707;
  localparam logic [63:0] ERR_O   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] START_O = 64'h17161514131211FB;
  localparam logic [63:0] TERM_O  = 64'h070707FDA3A2A1A0;
  localparam logic [63:0] OS_O    = 64'h07070707C3C2C19C;

  typedef struct {
    logic         locked, bvalid, marker, clear;
    logic [263:0] blk;
    logic         valid;
    logic [255:0] data;
    logic [31:0]  ctrl;
    logic         err_block;
    logic [15:0]  count;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [65:0] db(input logic [63:0] d);
    return {d, 2'b10};
  endfunction

  function automatic vec_t mk(input logic locked, bvalid, marker, clear,
                              input logic [263:0] blk, input logic valid,
                              input logic [255:0] data, input logic [31:0] ctrl,
                              input logic err_block, input logic [15:0] count);
    vec_t v;
    v.locked = locked; v.bvalid = bvalid; v.marker = marker; v.clear = clear;
    v.blk = blk; v.valid = valid; v.data = data; v.ctrl = ctrl;
    v.err_block = err_block; v.count = count;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic locked, bvalid, marker, clear, input logic [263:0] blk);
    rx_locked = locked; rx_block_valid = bvalid; rx_marker = marker;
    rx_err_clear = clear; rx_block = blk;
    @(posedge core_clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input logic valid, input logic [255:0] data,
                               input logic [31:0] ctrl, input logic err_block, input logic [15:0] count);
    check("rx_valid", idx, {255'b0, rx_valid}, {255'b0, valid});
    check("rx_data", idx, rx_data, data);
    check("rx_ctrl", idx, {224'b0, rx_ctrl}, {224'b0, ctrl});
    check("rx_err_block", idx, {255'b0, rx_err_block}, {255'b0, err_block});
    check("rx_err_count", idx, {240'b0, rx_err_count}, {240'b0, count});
  endtask

  initial begin
    logic [263:0] idle4, err4;
    idle4 = {4{IDLE_B}};
    err4  = {4{66'h0}};

    tbl[0]  = mk(1, 1, 0, 0, idle4, 1, {4{IDLE_O}}, 32'hFFFFFFFF, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, idle4, 1, {4{IDLE_O}}, 32'hFFFFFFFF, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, {db(D3), db(D2), db(D1), START_B}, 1,
                 {D3, D2, D1, START_O}, 32'h00000001, 0, 0);
    // Marker mid-frame: garbage content must be ignored, outputs hold.
    tbl[3]  = mk(1, 1, 1, 0, err4, 0, {D3, D2, D1, START_O}, 32'h00000001, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, {db(D7), db(D6), db(D5), db(D4)}, 1, {D7, D6, D5, D4}, 32'h0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, {IDLE_B, IDLE_B, IDLE_B, TERM_B}, 1,
                 {IDLE_O, IDLE_O, IDLE_O, TERM_O}, 32'hFFFFFFF0, 0, 0);
    // Data while in C: lane 0 errored, idle in lane 1 recovers.
    tbl[6]  = mk(1, 1, 0, 0, {IDLE_B, IDLE_B, IDLE_B, db(D1)}, 1,
                 {IDLE_O, IDLE_O, IDLE_O, ERR_O}, 32'hFFFFFFFF, 1, 1);
    // Back-to-back frames in one word: S T S D.
    tbl[7]  = mk(1, 1, 0, 0, {db(D1), START_B, TERM_B, START_B}, 1,
                 {D1, START_O, TERM_O, START_O}, 32'h0001F001, 0, 1);
    // Sync 11 in lane 2 mid-frame: lanes 2 and 3 errored.
    tbl[8]  = mk(1, 1, 0, 0, {db(D4), SYNC3_B, db(D3), db(D2)}, 1,
                 {ERR_O, ERR_O, D3, D2}, 32'hFFFF0000, 1, 3);
    tbl[9]  = mk(1, 1, 0, 0, {db(D7), db(D6), db(D5), START_B}, 1,
                 {D7, D6, D5, START_O}, 32'h00000001, 0, 3);
    // Lock drop while in a frame: state returns to INIT.
    tbl[10] = mk(0, 1, 0, 0, idle4, 0, {D7, D6, D5, START_O}, 32'h00000001, 0, 3);
    tbl[11] = mk(1, 1, 0, 0, {IDLE_B, IDLE_B, IDLE_B, db(D1)}, 1,
                 {IDLE_O, IDLE_O, IDLE_O, ERR_O}, 32'hFFFFFFFF, 1, 4);
    tbl[12] = mk(1, 1, 0, 0, {IDLE_B, OS_B, IDLE_B, OS_B}, 1,
                 {IDLE_O, OS_O, IDLE_O, OS_O}, 32'hFFF1FFF1, 0, 4);
    tbl[13] = mk(1, 0, 0, 0, err4, 0, {IDLE_O, OS_O, IDLE_O, OS_O}, 32'hFFF1FFF1, 0, 4);
    tbl[14] = mk(1, 1, 0, 1, idle4, 1, {4{IDLE_O}}, 32'hFFFFFFFF, 0, 0);
    tbl[15] = mk(1, 1, 0, 0, {BADT_B, IDLE_B, BADI_B, IDLE_B}, 1,
                 {ERR_O, IDLE_O, ERR_O, IDLE_O}, 32'hFFFFFFFF, 1, 2);

    #22;
    check_outputs(-1, 0, {32{8'h07}}, 32'hFFFFFFFF, 0, 0);
    core_reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].locked, tbl[i].bvalid, tbl[i].marker, tbl[i].clear, tbl[i].blk);
      check_outputs(i, tbl[i].valid, tbl[i].data, tbl[i].ctrl, tbl[i].err_block, tbl[i].count);
    end

    // Clear beats a same-cycle increment of 4.
    drive(1, 1, 0, 1, err4);
    check("clear_wins", 100, {240'b0, rx_err_count}, 256'd0);
    check("clear_err_block", 100, {255'b0, rx_err_block}, 256'd1);

    // Drive the counter up to just below saturation, then across it.
    for (int i = 0; i < 16383; i++) drive(1, 1, 0, 0, err4);
    check("count_near_sat", 101, {240'b0, rx_err_count}, 256'hFFFC);
    check("err_word_data", 101, rx_data, {32{8'hFE}});
    drive(1, 1, 0, 0, err4);
    check("count_at_sat", 102, {240'b0, rx_err_count}, 256'hFFFF);
    drive(1, 1, 0, 0, err4);
    check("count_holds_sat", 103, {240'b0, rx_err_count}, 256'hFFFF);
    drive(1, 1, 0, 1, err4);
    check("clear_from_sat", 104, {240'b0, rx_err_count}, 256'd0);
    check("clear_valid", 104, {255'b0, rx_valid}, 256'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
